// File: rtl/ws2812_pkg.sv
// Shared types, default 100 MHz timing and helpers for the WS2812 strip driver.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        LATCH
    } state_t;

    localparam int T_BIT_100MHZ   = 125;
    localparam int T0H_100MHZ     = 34;
    localparam int T1H_100MHZ     = 89;
    localparam int T_RESET_100MHZ = 5900;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Per-bit cycle counter; dout is registered from next-cycle values so the
// first high cycle lands on the cycle right after the timer is enabled.
module ws2812_bit_timer
#(
    parameter int T_BIT = 125,
    parameter int T0H   = 34,
    parameter int T1H   = 89,
    parameter int CW    = 13
)
(
    input  logic clk,
    input  logic reset,
    input  logic en,        // timer runs in the coming cycle
    input  logic bit_val,   // bit on the wire in the coming cycle
    output logic dout,
    output logic bit_end    // current cycle is the last cycle of a bit
);

    logic [CW-1:0] cyc, cyc_n;
    logic          run;

    always_comb begin
        cyc_n = '0;
        if (en && run && cyc != CW'(T_BIT - 1))
            cyc_n = cyc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc  <= '0;
            run  <= 1'b0;
            dout <= 1'b0;
        end else begin
            cyc  <= cyc_n;
            run  <= en;
            dout <= en && (cyc_n < (bit_val ? CW'(T1H) : CW'(T0H)));
        end
    end

    assign bit_end = run && (cyc == CW'(T_BIT - 1));

endmodule

// File: rtl/ws2812_strip_driver.sv
// WS2812/SK6812 strip driver: pulls NUM_LEDS pixels per frame, serialises
// them MSB-first as NRZ pulses, then holds the latch interval.
module ws2812_strip_driver
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = 56,
    parameter int COLOUR_W = 24,
    parameter int T_BIT    = T_BIT_100MHZ,
    parameter int T0H      = T0H_100MHZ,
    parameter int T1H      = T1H_100MHZ,
    parameter int T_RESET  = T_RESET_100MHZ,
    localparam int IW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [COLOUR_W-1:0] pix_data,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic [IW-1:0]       led_idx,
    output logic                dout,
    output logic                busy,
    output logic                done,
    output logic                underrun
);

    localparam int CW = $clog2(max2(T_BIT, T_RESET));
    localparam int PW = $clog2(NUM_LEDS + 1);
    localparam int BW = (COLOUR_W > 1) ? $clog2(COLOUR_W) : 1;

    state_t              state, state_n;
    logic [COLOUR_W-1:0] shreg, shreg_n, pbuf, pbuf_n;
    logic                pbuf_vld, pbuf_vld_n;
    logic [BW-1:0]       bit_cnt, bit_cnt_n;
    logic [PW-1:0]       pix_cnt, pix_cnt_n;
    logic [IW-1:0]       idx_n;
    logic [CW-1:0]       lat_cnt, lat_cnt_n;
    logic                accept, bit_end, last_bit, more_pix;

    assign pix_ready = (state == LOAD) ||
                       (state == SEND && !pbuf_vld && pix_cnt < PW'(NUM_LEDS));
    assign accept    = pix_valid && pix_ready;
    assign last_bit  = (bit_cnt == BW'(COLOUR_W - 1));
    assign more_pix  = (led_idx < IW'(NUM_LEDS - 1));
    assign busy      = (state != IDLE);
    assign done      = (state == LATCH) && (lat_cnt == CW'(T_RESET - 1));
    // A pixel arriving on the very last cycle still counts as in time.
    assign underrun  = (state == SEND) && bit_end && last_bit && more_pix &&
                       !pbuf_vld && !accept;

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        pbuf_n     = pbuf;
        pbuf_vld_n = pbuf_vld;
        bit_cnt_n  = bit_cnt;
        pix_cnt_n  = pix_cnt;
        idx_n      = led_idx;
        lat_cnt_n  = lat_cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n    = LOAD;
                    pix_cnt_n  = '0;
                    idx_n      = '0;
                    pbuf_vld_n = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    shreg_n   = pix_data;
                    bit_cnt_n = '0;
                    pix_cnt_n = pix_cnt + 1'b1;
                    state_n   = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    pix_cnt_n  = pix_cnt + 1'b1;
                    pbuf_n     = pix_data;
                    pbuf_vld_n = 1'b1;
                end
                if (bit_end) begin
                    if (!last_bit) begin
                        shreg_n   = shreg << 1;
                        bit_cnt_n = bit_cnt + 1'b1;
                    end else if (more_pix && (pbuf_vld || accept)) begin
                        shreg_n    = pbuf_vld ? pbuf : pix_data;
                        pbuf_vld_n = 1'b0;
                        bit_cnt_n  = '0;
                        idx_n      = led_idx + 1'b1;
                    end else begin
                        state_n    = LATCH;
                        lat_cnt_n  = '0;
                        pbuf_vld_n = 1'b0;
                    end
                end
            end
            LATCH: begin
                lat_cnt_n = lat_cnt + 1'b1;
                if (done)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            shreg    <= '0;
            pbuf     <= '0;
            pbuf_vld <= 1'b0;
            bit_cnt  <= '0;
            pix_cnt  <= '0;
            led_idx  <= '0;
            lat_cnt  <= '0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            pbuf     <= pbuf_n;
            pbuf_vld <= pbuf_vld_n;
            bit_cnt  <= bit_cnt_n;
            pix_cnt  <= pix_cnt_n;
            led_idx  <= idx_n;
            lat_cnt  <= lat_cnt_n;
        end
    end

    ws2812_bit_timer #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H),
        .CW    (CW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .en      (state_n == SEND),
        .bit_val (shreg_n[COLOUR_W-1]),
        .dout    (dout),
        .bit_end (bit_end)
    );

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Directed bench: per-cycle expected line state is queued from a pulse model
// and compared against two driver instances (24-bit x2 LEDs, 32-bit x1 LED).
module tb_ws2812_strip_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_start, a_valid, a_ready, a_dout, a_busy, a_done, a_under;
    logic [23:0] a_data;
    logic [0:0]  a_idx;

    logic        b_start, b_valid, b_ready, b_dout, b_busy, b_done, b_under;
    logic [31:0] b_data;
    logic [0:0]  b_idx;

    ws2812_strip_driver #(
        .NUM_LEDS(2), .COLOUR_W(24), .T_BIT(10), .T0H(3), .T1H(7), .T_RESET(20)
    ) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .pix_data(a_data),
        .pix_valid(a_valid), .pix_ready(a_ready), .led_idx(a_idx),
        .dout(a_dout), .busy(a_busy), .done(a_done), .underrun(a_under)
    );

    ws2812_strip_driver #(
        .NUM_LEDS(1), .COLOUR_W(32), .T_BIT(10), .T0H(3), .T1H(7), .T_RESET(20)
    ) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .pix_data(b_data),
        .pix_valid(b_valid), .pix_ready(b_ready), .led_idx(b_idx),
        .dout(b_dout), .busy(b_busy), .done(b_done), .underrun(b_under)
    );

    typedef struct packed {
        logic dout;
        logic busy;
        logic done;
        logic under;
        logic idx;
    } obs_t;

    obs_t q[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [39:0] act, input logic [39:0] exp);
        vectors++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // Model: each bit is 10 cycles, high for 7 (one) or 3 (zero).
    task automatic push_pixel(input logic [31:0] p, input int w, input logic idx,
                              input bit under_last);
        obs_t e;
        for (int b = w - 1; b >= 0; b--) begin
            for (int c = 0; c < 10; c++) begin
                e.dout  = (c < (p[b] ? 7 : 3));
                e.busy  = 1'b1;
                e.done  = 1'b0;
                e.under = under_last && (b == 0) && (c == 9);
                e.idx   = idx;
                q.push_back(e);
            end
        end
    endtask

    task automatic push_latch(input logic idx);
        obs_t e;
        for (int i = 0; i < 20; i++) begin
            e.dout  = 1'b0;
            e.busy  = 1'b1;
            e.done  = (i == 19);
            e.under = 1'b0;
            e.idx   = idx;
            q.push_back(e);
        end
    endtask

    // p1_at: data cycle on which pixel 1 first becomes valid, -1 = never.
    task automatic frame_a(input string nm, input logic [23:0] p0, input logic [23:0] p1,
                           input int p1_at, input bit spam);
        bit   taken = 1'b0;
        bit   und   = (p1_at < 0);
        int   c     = 0;
        obs_t e, o;
        push_pixel({8'h0, p0}, 24, 1'b0, und);
        if (!und) push_pixel({8'h0, p1}, 24, 1'b1, 1'b0);
        push_latch(und ? 1'b0 : 1'b1);
        a_start = 1'b1; a_valid = 1'b1; a_data = p0;
        step();
        a_start = spam;
        #1;
        check({nm, "_load"}, {36'h0, a_ready, a_busy, a_dout, a_idx}, 40'hC);
        step();
        a_data = p1;
        while (q.size() > 0) begin
            e = q.pop_front();
            a_start = spam;
            a_valid = (p1_at >= 0) && (c >= p1_at) && !taken;
            #1;
            o = '{a_dout, a_busy, a_done, a_under, a_idx[0]};
            check($sformatf("%s_cyc%0d", nm, c), {35'h0, o}, {35'h0, e});
            if (a_valid && a_ready) taken = 1'b1;
            step();
            c++;
        end
        a_start = 1'b0; a_valid = 1'b0;
        #1;
        check({nm, "_idle"}, {36'h0, a_busy, a_dout, a_ready, a_done}, 40'h0);
    endtask

    task automatic frame_b(input logic [31:0] p);
        int   c = 0;
        obs_t e, o;
        push_pixel(p, 32, 1'b0, 1'b0);
        push_latch(1'b0);
        b_start = 1'b1; b_valid = 1'b1; b_data = p;
        step();
        b_start = 1'b0;
        #1;
        check("b_load", {36'h0, b_ready, b_busy, b_dout, b_idx}, 40'hC);
        step();
        b_valid = 1'b0;
        while (q.size() > 0) begin
            e = q.pop_front();
            #1;
            o = '{b_dout, b_busy, b_done, b_under, b_idx[0]};
            check($sformatf("b_cyc%0d", c), {35'h0, o}, {35'h0, e});
            if (c == 0) check("b_ready_full", {39'h0, b_ready}, 40'h0);
            step();
            c++;
        end
        #1;
        check("b_idle", {36'h0, b_busy, b_dout, b_ready, b_done}, 40'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        a_start = 1'b0; a_valid = 1'b0; a_data = '0;
        b_start = 1'b0; b_valid = 1'b0; b_data = '0;
        repeat (3) step();
        #1;
        check("reset_a", {34'h0, a_dout, a_ready, a_busy, a_done, a_under, a_idx}, 40'h0);
        check("reset_b", {34'h0, b_dout, b_ready, b_busy, b_done, b_under, b_idx}, 40'h0);
        reset = 1'b1;
        step();

        frame_a("norm", 24'h800001, 24'h000000, 0, 1'b0);
        step();
        frame_a("under", 24'h800001, 24'h000000, -1, 1'b0);
        step();
        frame_a("spam", 24'hC3A501, 24'h7E0081, 0, 1'b1);
        step();
        frame_a("late", 24'h800001, 24'h5A0F33, 239, 1'b0);
        step();

        // Abort a frame mid-SEND with reset, then run a clean frame.
        a_start = 1'b1; a_valid = 1'b1; a_data = 24'hA5A5A5;
        step();
        a_start = 1'b0;
        repeat (50) step();
        #1;
        check("pre_rst_busy", {39'h0, a_busy}, 40'h1);
        reset = 1'b0;
        step();
        #1;
        check("mid_rst", {37'h0, a_dout, a_busy, a_ready}, 40'h0);
        reset = 1'b1; a_valid = 1'b0;
        step();
        frame_a("post_rst", 24'h800001, 24'h000000, 0, 1'b0);
        step();

        frame_b(32'hFFFFFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_strip_driver.md
# ws2812_strip_driver

Parametrised serial driver for one WS2812/SK6812-class addressable LED strip in the POV display path. Each frame pulls NUM_LEDS pixel words from an upstream frame buffer through a valid/ready handshake and serialises them MSB-first as fixed-period NRZ pulses. It then holds the line low for the latch/reset interval and reports completion. Compared with the previous single-purpose driver, it adds configurable pulse timing and colour width (RGB or RGBW), explicit frame start/done control, one-pixel prefetch and underrun detection.

## Interface
- NUM_LEDS, 56: pixels per frame (≥1)
- COLOUR_W, 24: bits per pixel (24 GRB, 32 GRBW)
- T_BIT, 125: clk cycles per bit
- T0H, 34: high cycles for a 0 bit (1 ≤ T0H < T1H)
- T1H, 89: high cycles for a 1 bit (T1H < T_BIT)
- T_RESET, 5900: low cycles for the latch interval after the last bit
- clk  in  1  system clock
- reset  in  1  synchronous, active-low
- start  in  1  single-cycle frame request; honoured only in IDLE
- pix_data  in  COLOUR_W  pixel word, MSB transmitted first
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  driver can accept a pixel
- led_idx  out  $clog2(NUM_LEDS)  index of the pixel currently on the wire
- dout  out  1  strip data line, registered
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when the latch interval completes
- underrun  out  1  one-cycle pulse when a pixel was not available in time

## Operation
- States: IDLE, LOAD, SEND, LATCH.
- IDLE:
  - dout=0, pix_ready=0, busy=0.
  - start=1 → LOAD. The pixel counter and led_idx clear to 0.
- LOAD:
  - pix_ready=1 and the driver waits for the first pixel. There is no timeout.
  - On accept (pix_valid & pix_ready), the word goes to the shift register, bit_cnt=0, cyc_cnt=0, and the state moves to SEND.
- SEND:
  - A cycle counter runs 0..T_BIT-1.
  - dout=1 while cyc_cnt < (current bit ? T1H : T0H), otherwise 0.
  - At cyc_cnt=T_BIT-1, the shift register shifts left and bit_cnt increments.
- Prefetch buffer:
  - One-entry buffer. pix_ready=1 in SEND while the buffer is empty and fewer than NUM_LEDS pixels have been accepted in the frame.
  - An accept fills the buffer.
- End of pixel (last cycle of bit COLOUR_W-1):
  - If pixels remain and the buffer is full: buffer → shift register, buffer empties, led_idx increments, SEND continues with no gap.
  - If pixels remain and the buffer is empty: underrun pulses, the frame aborts, and the state goes to LATCH. dout is low from the next cycle.
  - If this was the last pixel: go to LATCH.
- LATCH:
  - dout=0 for exactly T_RESET cycles.
  - done pulses on the last LATCH cycle, then the state returns to IDLE.
- start outside IDLE is ignored. pix_valid outside LOAD/SEND is ignored.
- Reset (reset=0) at any time:
  - state=IDLE, all counters and the buffer clear.
  - dout, pix_ready, busy, done and underrun are all 0; led_idx=0.

## Timing
- start accepted at edge k → LOAD and pix_ready=1 from k+1.
- Pixel accepted at edge m → first dout high on the cycle after m.
- Each bit occupies exactly T_BIT cycles. Consecutive pixels have no gap.
- Frame with pixels always available: NUM_LEDS·COLOUR_W·T_BIT cycles of data, then T_RESET low cycles, then done.
- busy rises the cycle after start acceptance and falls the cycle after done.
- The buffer must be filled before the final cycle of the current pixel. A pixel accepted on that final cycle is used with no gap.
- Counter widths: cyc_cnt is $clog2(max(T_BIT, T_RESET)) bits. The pixel counter saturates at NUM_LEDS.

## Structure
- Package ws2812_pkg holds:
  - the state enum typedef;
  - the default timing localparams: T_BIT_100MHZ=125, T0H_100MHZ=34, T1H_100MHZ=89, T_RESET_100MHZ=5900.
- Sub-module ws2812_bit_timer holds the cycle counter and high/low comparison. Inputs are bit value and enable; outputs are dout and bit_end.
- The top level holds the FSM, shift register, prefetch buffer and index logic.

## Test plan
Parameters for the directed scenarios are NUM_LEDS=2, COLOUR_W=24, T_BIT=10, T0H=3, T1H=7, T_RESET=20, unless stated otherwise.
- Pixels 0x800001 and 0x000000, always valid → 48 bits × 10 cycles.
  - Bit 0 is high for 7 cycles, bits 1–22 are high for 3, bit 23 is high for 7; pixel 2 is 24 bits high for 3.
  - 20 low cycles follow, then one done pulse, and the total busy span matches.
- pix_valid withheld after pixel 0 → underrun pulses at the end of bit 23; dout=0 for 20 cycles; done pulses; led_idx stays 0.
- start repeated mid-frame → no effect on the waveform or on busy.
- reset asserted mid-SEND → the next cycle has dout=0, busy=0, pix_ready=0, state IDLE; a fresh start runs a normal frame.
- COLOUR_W=32, NUM_LEDS=1, pixel 0xFFFFFFFF → 32 bits, each high 7 and low 3, then latch and done.
- Pixel 1 presented on the final cycle of pixel 0 → accepted, with no gap between pixels on dout.
